// File: rtl/axi4_lite_subordinate.sv
// rtl/axi4_lite_subordinate.sv - AXI4-Lite subordinate bridging to a word-wide request/ack memory port
//
// Terminates one AXI4-Lite subordinate port (AR/R/AW/W/B channels, flattened)
// and drives a request/ack mem_* port. One read and one write may be in
// flight; they share the mem port through an alternating arbiter.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   ar*/r*                        read address / read data channels
//   aw*/w*/b*                     write address / write data / write response channels
//   mem_rd_en, mem_wr_en          requests, held until mem_ack or timeout
//   mem_addr                      word-aligned byte offset from BASE_ADDR
//   mem_wr_data, mem_wr_strobe    write payload and byte enables
//   mem_rd_data, mem_ack, mem_err completion from the peripheral
module axi4_lite_subordinate #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    XLEN       = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH:0]   SIZE       = 'h1000,
    parameter int                    TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [XLEN-1:0]       rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN/8-1:0]     wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wr_data,
    output logic [XLEN/8-1:0]     mem_wr_strobe,
    input  logic [XLEN-1:0]       mem_rd_data,
    input  logic                  mem_ack,
    input  logic                  mem_err
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam int         TW          = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TIMEOUT_CNT = TW'(TIMEOUT);

    typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_RESP} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_RD, OWN_WR} owner_t;

    rd_state_t rd_state, rd_state_next;
    wr_state_t wr_state, wr_state_next;
    owner_t    owner;

    logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
    logic [XLEN-1:0]       rdata_q, wdata_q, rd_data_next;
    logic [XLEN/8-1:0]     wstrb_q;
    logic [1:0]            rresp_q, bresp_q, rd_resp_next, wr_resp_next;
    logic                  rd_load, wr_load;
    logic                  aw_held, w_held, aw_hs, w_hs;
    logic                  prio_rd;
    logic [TW-1:0]         cnt_q, cur_cnt;
    logic                  rd_need, wr_need, rd_sel, wr_sel, busy, timeout, finish;

    // Extra top bit is the borrow of addr - BASE_ADDR, so addresses below the
    // window compare as huge and fall out of range without a second compare.
    logic [ADDR_WIDTH:0] rd_diff, wr_diff;
    logic                rd_in_range, wr_in_range;

    assign rd_diff     = {1'b0, rd_addr} - {1'b0, BASE_ADDR};
    assign wr_diff     = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
    assign rd_in_range = rd_diff < SIZE;
    assign wr_in_range = wr_diff < SIZE;

    logic unused_ok;
    assign unused_ok = ^{arprot, awprot, rd_diff[1:0], wr_diff[1:0]};

    // Arbiter: an idle port is granted to whichever side needs it, with
    // prio_rd breaking ties; an owned port stays with its owner.
    assign rd_need = (rd_state == RD_REQ) && rd_in_range;
    assign wr_need = (wr_state == WR_REQ) && wr_in_range;
    assign rd_sel  = rst_n && rd_need &&
                     ((owner == OWN_RD) || ((owner == OWN_NONE) && (!wr_need || prio_rd)));
    assign wr_sel  = rst_n && wr_need &&
                     ((owner == OWN_WR) || ((owner == OWN_NONE) && (!rd_need || !prio_rd)));
    assign busy    = rd_sel || wr_sel;
    assign cur_cnt = (owner == OWN_NONE) ? '0 : cnt_q;
    // mem_ack in the expiry cycle wins over the timeout.
    assign timeout = busy && !mem_ack && (cur_cnt == TIMEOUT_CNT);
    assign finish  = busy && (mem_ack || timeout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner   <= OWN_NONE;
            prio_rd <= 1'b1;
            cnt_q   <= '0;
        end else if (finish) begin
            owner   <= OWN_NONE;
            prio_rd <= wr_sel;
            cnt_q   <= '0;
        end else if (busy) begin
            owner   <= rd_sel ? OWN_RD : OWN_WR;
            cnt_q   <= cur_cnt + TW'(1);
        end
    end

    assign mem_rd_en     = rd_sel;
    assign mem_wr_en     = wr_sel;
    assign mem_addr      = rd_sel ? {rd_diff[ADDR_WIDTH-1:2], 2'b00} :
                           wr_sel ? {wr_diff[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_wr_data   = wr_sel ? wdata_q : '0;
    assign mem_wr_strobe = wr_sel ? wstrb_q : '0;

    // Read path
    assign arready = rst_n && (rd_state == RD_IDLE);
    assign rvalid  = rst_n && (rd_state == RD_RESP);
    assign rdata   = rst_n ? rdata_q : '0;
    assign rresp   = rst_n ? rresp_q : RESP_OKAY;

    always_comb begin
        rd_state_next = rd_state;
        rd_load       = 1'b0;
        rd_data_next  = '0;
        rd_resp_next  = RESP_OKAY;
        case (rd_state)
            RD_IDLE: if (arvalid) rd_state_next = RD_REQ;
            RD_REQ: begin
                if (!rd_in_range) begin
                    rd_load      = 1'b1;
                    rd_resp_next = RESP_DECERR;
                end else if (rd_sel && mem_ack) begin
                    rd_load      = 1'b1;
                    rd_resp_next = mem_err ? RESP_SLVERR : RESP_OKAY;
                    rd_data_next = mem_err ? '0 : mem_rd_data;
                end else if (rd_sel && timeout) begin
                    rd_load      = 1'b1;
                    rd_resp_next = RESP_SLVERR;
                end
                if (rd_load) rd_state_next = RD_RESP;
            end
            RD_RESP: if (rready) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_next;
            if (rd_state == RD_IDLE && arvalid) rd_addr <= araddr;
            if (rd_load) begin
                rdata_q <= rd_data_next;
                rresp_q <= rd_resp_next;
            end
        end
    end

    // Write path: AW and W are captured independently in WR_IDLE.
    assign awready = rst_n && (wr_state == WR_IDLE) && !aw_held;
    assign wready  = rst_n && (wr_state == WR_IDLE) && !w_held;
    assign bvalid  = rst_n && (wr_state == WR_RESP);
    assign bresp   = rst_n ? bresp_q : RESP_OKAY;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    always_comb begin
        wr_state_next = wr_state;
        wr_load       = 1'b0;
        wr_resp_next  = RESP_OKAY;
        case (wr_state)
            WR_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) wr_state_next = WR_REQ;
            WR_REQ: begin
                if (!wr_in_range) begin
                    wr_load      = 1'b1;
                    wr_resp_next = RESP_DECERR;
                end else if (wr_sel && mem_ack) begin
                    wr_load      = 1'b1;
                    wr_resp_next = mem_err ? RESP_SLVERR : RESP_OKAY;
                end else if (wr_sel && timeout) begin
                    wr_load      = 1'b1;
                    wr_resp_next = RESP_SLVERR;
                end
                if (wr_load) wr_state_next = WR_RESP;
            end
            WR_RESP: if (bready) wr_state_next = WR_IDLE;
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state <= WR_IDLE;
            wr_addr  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_next;
            if (aw_hs) begin
                wr_addr <= awaddr;
                aw_held <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
                w_held  <= 1'b1;
            end
            // Flags clear as the request starts; this overrides a same-cycle capture.
            if (wr_state == WR_IDLE && wr_state_next == WR_REQ) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
            if (wr_load) bresp_q <= wr_resp_next;
        end
    end

endmodule

// File: tb/tb_axi4_lite_subordinate.sv
// tb/tb_axi4_lite_subordinate.sv - directed self-checking bench for axi4_lite_subordinate
module tb_axi4_lite_subordinate;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr, awaddr, wdata, rdata, mem_addr, mem_wr_data, mem_rd_data;
    logic [2:0]  arprot, awprot;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb, mem_wr_strobe;
    logic        mem_rd_en, mem_wr_en, mem_ack, mem_err;
    logic        ack_mode, err_mode;

    int checks = 0;
    int errors = 0;
    int rd_en_cnt = 0;
    int wr_en_cnt = 0;
    int both_cnt = 0;
    int n, r0, w0;

    always #5 clk = ~clk;

    // Peripheral stand-in: acks in the same cycle as the request when enabled.
    assign mem_ack = ack_mode & (mem_rd_en | mem_wr_en);
    assign mem_err = err_mode;

    axi4_lite_subordinate #(
        .ADDR_WIDTH(32), .XLEN(32), .BASE_ADDR(32'h0), .SIZE(33'h1000), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strobe(mem_wr_strobe),
        .mem_rd_data(mem_rd_data), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always @(posedge clk) begin
        if (mem_rd_en) rd_en_cnt++;
        if (mem_wr_en) wr_en_cnt++;
        if (mem_rd_en && mem_wr_en) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_ar(input logic [31:0] addr);
        araddr  = addr;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        #1;
    endtask

    task automatic issue_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        #1;
    endtask

    task automatic wait_rvalid(input int max, output int cyc);
        cyc = 0;
        while (!rvalid && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        chk("rvalid_seen", {31'b0, rvalid}, 32'd1);
    endtask

    task automatic wait_bvalid(input int max, output int cyc);
        cyc = 0;
        while (!bvalid && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        chk("bvalid_seen", {31'b0, bvalid}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; araddr = '0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b1;
        awaddr = '0; awprot = 3'd0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; mem_rd_data = '0; ack_mode = 1'b1; err_mode = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rresp", {30'b0, rresp}, 32'd0);
        chk("rst_bresp", {30'b0, bresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_en", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {29'b0, arready, awready, wready}, 32'h7);

        // Contention right after reset: read wins first, write follows.
        mem_rd_data = 32'h1111_2222;
        araddr = 32'h10; arvalid = 1'b1;
        awaddr = 32'h14; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("cont_first_rd", {30'b0, mem_rd_en, mem_wr_en}, 32'h2);
        chk("cont_rd_addr", mem_addr, 32'h10);
        @(negedge clk);
        chk("cont_second_wr", {30'b0, mem_rd_en, mem_wr_en}, 32'h1);
        chk("cont_wr_addr", mem_addr, 32'h14);
        chk("cont_rdata", rdata, 32'h1111_2222);
        @(negedge clk);
        chk("cont_bvalid", {31'b0, bvalid}, 32'd1);
        chk("cont_bresp", {30'b0, bresp}, 32'd0);
        @(negedge clk);
        chk("never_both_en", both_cnt, 32'd0);

        // Zero-wait read
        mem_rd_data = 32'hDEAD_BEEF; rready = 1'b0;
        issue_ar(32'h4);
        chk("zw_rd_en_n1", {31'b0, mem_rd_en}, 32'd1);
        chk("zw_addr", mem_addr, 32'h4);
        chk("zw_rvalid_n1", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        chk("zw_rvalid_n2", {31'b0, rvalid}, 32'd1);
        chk("zw_rdata", rdata, 32'hDEAD_BEEF);
        chk("zw_rresp", {30'b0, rresp}, 32'd0);
        rready = 1'b1;
        @(negedge clk);
        chk("zw_done", {30'b0, rvalid, arready}, 32'h1);

        // W three cycles ahead of AW
        w0 = wr_en_cnt;
        wdata = 32'h1234_5678; wstrb = 4'h3; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        #1;
        chk("wo_ready_after_w", {29'b0, wready, awready, mem_wr_en}, 32'h2);
        repeat (2) @(negedge clk);
        awaddr = 32'h8; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        #1;
        chk("wo_wr_en", {31'b0, mem_wr_en}, 32'd1);
        chk("wo_addr", mem_addr, 32'h8);
        chk("wo_data", mem_wr_data, 32'h1234_5678);
        chk("wo_strb", {28'b0, mem_wr_strobe}, 32'h3);
        @(negedge clk);
        chk("wo_bvalid", {31'b0, bvalid}, 32'd1);
        chk("wo_bresp", {30'b0, bresp}, 32'd0);
        chk("wo_one_access", wr_en_cnt - w0, 32'd1);
        @(negedge clk);

        // Decode errors
        r0 = rd_en_cnt;
        issue_ar(32'h1000);
        wait_rvalid(10, n);
        chk("dec_rd_latency", n, 32'd1);
        chk("dec_rresp", {30'b0, rresp}, 32'h3);
        chk("dec_rdata", rdata, 32'd0);
        chk("dec_no_rd_en", rd_en_cnt - r0, 32'd0);
        @(negedge clk);
        w0 = wr_en_cnt;
        issue_wr(32'h2000, 32'hFFFF_FFFF, 4'hF);
        wait_bvalid(10, n);
        chk("dec_wr_latency", n, 32'd1);
        chk("dec_bresp", {30'b0, bresp}, 32'h3);
        chk("dec_no_wr_en", wr_en_cnt - w0, 32'd0);
        @(negedge clk);

        // Timeout: enable held for counts 0..TIMEOUT then SLVERR
        ack_mode = 1'b0;
        r0 = rd_en_cnt;
        issue_ar(32'h20);
        wait_rvalid(20, n);
        chk("to_latency", n, 32'd5);
        chk("to_rresp", {30'b0, rresp}, 32'h2);
        chk("to_rdata", rdata, 32'd0);
        chk("to_en_cycles", rd_en_cnt - r0, 32'd5);
        @(negedge clk);
        ack_mode = 1'b1;

        // mem_err on a write
        err_mode = 1'b1;
        issue_wr(32'h24, 32'h0BAD_0BAD, 4'hF);
        wait_bvalid(10, n);
        chk("err_bresp", {30'b0, bresp}, 32'h2);
        @(negedge clk);
        err_mode = 1'b0;

        // R backpressure: response held while peripheral data changes
        mem_rd_data = 32'hCAFE_F00D; rready = 1'b0;
        issue_ar(32'h30);
        wait_rvalid(10, n);
        mem_rd_data = 32'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rdata", rdata, 32'hCAFE_F00D);
            chk("bp_rresp_valid", {29'b0, rvalid, rresp}, 32'h4);
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        chk("bp_released", {31'b0, rvalid}, 32'd0);

        // Reset in the middle of a stalled write request
        ack_mode = 1'b0;
        issue_wr(32'h40, 32'h55, 4'hF);
        chk("mid_wr_en", {31'b0, mem_wr_en}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_en", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_data", mem_wr_data, 32'd0);
        chk("mid_rst_strb", {28'b0, mem_wr_strobe}, 32'd0);
        chk("mid_rst_valids", {28'b0, bvalid, rvalid, awready, arready}, 32'd0);
        rst_n = 1'b1;
        ack_mode = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_b", {30'b0, bvalid, awready}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
